// File: rtl/sim_uart_pkg.sv
// Shared types and defaults for the simulation-side UART client.
package sim_uart_pkg;

    localparam int DEF_CLOCK_FREQ = 48_000_000;
    localparam int DEF_BAUD       = 115_200;

    typedef enum logic [2:0] {
        RxIdle,
        RxStart,
        RxData,
        RxStop,
        RxComplete,
        RxBreak
    } RxState;

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead byte FIFO; a write while full is only accepted if a pop frees a slot.
module uart_rx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       sourceClk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       empty,
    output logic       full
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_rd, do_wr;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign rd_data = mem_q[rptr_q];
    assign do_rd   = rd_en & ~empty;
    assign do_wr   = wr_en & (~full | do_rd);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (do_wr) wptr_d = wptr_q + AW'(1);
        if (do_rd) rptr_d = rptr_q + AW'(1);
        unique case ({do_wr, do_rd})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge sourceClk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge sourceClk) begin
        if (do_wr) mem_q[wptr_q] <= wr_data;
    end

endmodule

// File: rtl/uart_rx_client.sv
// 8N1 UART receiver for the sim client: deserializes the SoC tx line into a FIFO.
module uart_rx_client
    import sim_uart_pkg::*;
#(
    parameter int CLOCK_FREQ = DEF_CLOCK_FREQ,
    parameter int BAUD       = DEF_BAUD,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       sourceClk,
    input  logic       reset,
    input  logic       cs,
    input  logic       rx_in,
    input  logic       rd_en,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_complete,
    output logic       frame_err,
    output logic       overflow,
    output logic       busy
);

    localparam int CPB = CLOCK_FREQ / BAUD;
    localparam int CW  = $clog2(CPB);
    localparam logic [CW-1:0] HALF_M1 = CW'(CPB / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CPB - 1);

    RxState        state_q, state_d;
    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          ferr_q, ferr_d;
    logic          ovf_q, ovf_d;
    logic          push;
    logic          rx_s;
    logic [7:0]    fifo_data;
    logic          fifo_empty, fifo_full;

    assign rx_s = sync_q[1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        ferr_d  = ferr_q;
        push    = 1'b0;
        unique case (state_q)
            RxIdle: begin
                if (cs && !rx_s) begin
                    state_d = RxStart;
                    cnt_d   = '0;
                end
            end
            RxStart: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s ? RxIdle : RxData;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RxData: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shreg_d = {rx_s, shreg_q[7:1]};
                    if (idx_q == 3'd7) state_d = RxStop;
                    else               idx_d   = idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RxStop: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = RxComplete;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = RxBreak;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RxComplete: begin
                push    = 1'b1;
                state_d = RxIdle;
            end
            RxBreak: begin
                if (rx_s) state_d = RxIdle;
            end
            default: state_d = RxIdle;
        endcase
        // Dropping cs abandons any frame in flight silently.
        if (!cs && state_q != RxIdle) begin
            state_d = RxIdle;
            push    = 1'b0;
            ferr_d  = ferr_q;
        end
    end

    // When full the FIFO is non-empty, so rd_en alone decides whether a slot frees.
    assign ovf_d = ovf_q | (push & fifo_full & ~rd_en);

    always_ff @(posedge sourceClk) begin
        if (reset) begin
            sync_q  <= 2'b11;
            state_q <= RxIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            ferr_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx_in};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            ferr_q  <= ferr_d;
            ovf_q   <= ovf_d;
        end
    end

    uart_rx_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .sourceClk(sourceClk),
        .reset    (reset),
        .wr_en    (push),
        .wr_data  (shreg_q),
        .rd_en    (rd_en),
        .rd_data  (fifo_data),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    assign rx_byte     = fifo_empty ? 8'h00 : fifo_data;
    assign rx_valid    = ~fifo_empty;
    assign rx_complete = push;
    assign frame_err   = ferr_q;
    assign overflow    = ovf_q;
    assign busy        = (state_q != RxIdle);

endmodule

// File: tb/tb_uart_rx_client.sv
// Self-checking bench for uart_rx_client with a frame-level reference model.
module tb_uart_rx_client;

    localparam int CPB = 16;
    localparam int D   = 4;

    logic       sourceClk = 1'b0;
    logic       reset = 1'b1;
    logic       cs = 1'b1;
    logic       rx_in = 1'b1;
    logic       rd_en = 1'b0;
    logic [7:0] rx_byte;
    logic       rx_valid, rx_complete, frame_err, overflow, busy;

    uart_rx_client #(
        .CLOCK_FREQ(1_600_000),
        .BAUD      (100_000),
        .FIFO_DEPTH(D)
    ) dut (
        .sourceClk  (sourceClk),
        .reset      (reset),
        .cs         (cs),
        .rx_in      (rx_in),
        .rd_en      (rd_en),
        .rx_byte    (rx_byte),
        .rx_valid   (rx_valid),
        .rx_complete(rx_complete),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 sourceClk = ~sourceClk;

    int cyc = 0;
    always @(posedge sourceClk) cyc <= cyc + 1;

    // A frame starting at edge s decides its stop bit at edge s+155 and
    // lands in the FIFO at edge s+156 (sync 2 + half bit + 9 bit periods).
    typedef struct {
        int         dc;
        logic [7:0] b;
        bit         good;
    } ev_t;

    ev_t        ev[$];
    logic [7:0] mq[$];
    bit         mferr = 0, movf = 0;
    bit         pend_rd = 0, pend_rst = 1;
    bit         chk_en = 0, rnd_rd = 0;
    int         n_chk = 0, n_fail = 0, n_cmp = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge sourceClk) begin : model
        bit         pop, push, full, cmp;
        logic [7:0] pb;
        pb   = 8'h00;
        push = 0;
        if (pend_rst) begin
            mq.delete();
            ev.delete();
            mferr = 0;
            movf  = 0;
        end else begin
            pop = pend_rd && mq.size() > 0;
            if (ev.size() > 0 && ev[0].dc + 1 == cyc) begin
                push = ev[0].good;
                pb   = ev[0].b;
                void'(ev.pop_front());
            end
            full = (mq.size() == D);
            if (pop) void'(mq.pop_front());
            if (push) begin
                if (full && !pop) movf = 1;
                else              mq.push_back(pb);
            end
            if (ev.size() > 0 && ev[0].dc == cyc && !ev[0].good) mferr = 1;
        end
        cmp = ev.size() > 0 && ev[0].dc == cyc && ev[0].good;
        if (chk_en) begin
            chk("m_valid", rx_valid, mq.size() > 0);
            if (mq.size() > 0) chk("m_byte", rx_byte, mq[0]);
            chk("m_complete", rx_complete, cmp);
            chk("m_frame_err", frame_err, mferr);
            chk("m_overflow", overflow, movf);
        end
        if (rx_complete === 1'b1) n_cmp++;
        pend_rd  = rd_en;
        pend_rst = reset;
    end

    initial begin
        forever begin
            @(posedge sourceClk);
            #1;
            if (rnd_rd) rd_en = ($urandom_range(0, 9) < 3);
        end
    end

    task automatic send(input logic [7:0] b, input bit good, input int abort_k,
                        input int rst_k, input bit pop_c, input int gap);
        int s, slot;
        bit dead;
        dead = 0;
        @(posedge sourceClk);
        #1;
        s     = cyc;
        rx_in = 1'b0;
        if (abort_k < 0 && rst_k < 0) ev.push_back('{s + 155, b, good});
        for (int k = 1; k < 10 * CPB; k++) begin
            @(posedge sourceClk);
            #1;
            if (dead) begin
                if (k == rst_k + 1) begin
                    chk("rst_valid", rx_valid, 0);
                    chk("rst_byte", rx_byte, 0);
                    chk("rst_ferr", frame_err, 0);
                    chk("rst_ovf", overflow, 0);
                    chk("rst_busy", busy, 0);
                    chk("rst_cmp", rx_complete, 0);
                end
                reset = 1'b0;
                rx_in = 1'b1;
                continue;
            end
            slot  = k / CPB;
            rx_in = (slot == 0) ? 1'b0 : (slot <= 8) ? b[slot-1] : good;
            if (k == abort_k) cs = 1'b0;
            if (k == rst_k) begin
                chk("busy_mid", busy, 1);
                reset = 1'b1;
                rx_in = 1'b1;
                dead  = 1;
            end
            if (pop_c && k == 155) rd_en = 1'b1;
            if (pop_c && k == 156) rd_en = 1'b0;
        end
        @(posedge sourceClk);
        #1;
        rx_in = 1'b1;
        cs    = 1'b1;
        reset = 1'b0;
        repeat (gap) @(posedge sourceClk);
    endtask

    task automatic read_exp(input logic [7:0] e);
        @(posedge sourceClk);
        #1;
        chk("rd_valid", rx_valid, 1);
        chk("rd_byte", rx_byte, e);
        rd_en = 1'b1;
        @(posedge sourceClk);
        #1;
        rd_en = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge sourceClk);
        #1;
        reset = 1'b1;
        @(posedge sourceClk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int c0;
        repeat (3) @(posedge sourceClk);
        #1;
        reset = 1'b0;
        chk("reset_valid", rx_valid, 0);
        chk("reset_byte", rx_byte, 0);
        chk("reset_cmp", rx_complete, 0);
        chk("reset_ferr", frame_err, 0);
        chk("reset_ovf", overflow, 0);
        chk("reset_busy", busy, 0);
        chk_en = 1;

        c0 = n_cmp;
        send(8'h62, 1, -1, -1, 0, 4);
        chk("t1_pulses", n_cmp - c0, 1);
        chk("t1_byte", rx_byte, 8'h62);
        chk("t1_valid", rx_valid, 1);
        chk("t1_ferr", frame_err, 0);
        read_exp(8'h62);

        c0 = n_cmp;
        @(posedge sourceClk);
        #1;
        rx_in = 1'b0;
        repeat (5) @(posedge sourceClk);
        #1;
        rx_in = 1'b1;
        repeat (20) @(posedge sourceClk);
        #1;
        chk("t2_pulses", n_cmp - c0, 0);
        chk("t2_valid", rx_valid, 0);
        chk("t2_busy", busy, 0);

        send(8'hA5, 0, -1, -1, 0, 6);
        chk("t3_ferr", frame_err, 1);
        send(8'h3C, 1, -1, -1, 0, 4);
        read_exp(8'h3C);
        #1;
        chk("t3_empty", rx_valid, 0);

        for (int i = 1; i <= 5; i++) send(8'(i), 1, -1, -1, 0, 4);
        chk("t4_ovf", overflow, 1);
        for (int i = 1; i <= 4; i++) read_exp(8'(i));
        chk("t4_empty", rx_valid, 0);

        pulse_reset();
        for (int i = 1; i <= 4; i++) send(8'(i), 1, -1, -1, 0, 4);
        send(8'h77, 1, -1, -1, 1, 4);
        chk("t5_ovf", overflow, 0);
        read_exp(8'h02);
        read_exp(8'h03);
        read_exp(8'h04);
        read_exp(8'h77);

        c0 = n_cmp;
        send(8'h99, 1, 50, -1, 0, 6);
        chk("cs_pulses", n_cmp - c0, 0);
        chk("cs_valid", rx_valid, 0);
        chk("cs_busy", busy, 0);

        send(8'h11, 1, -1, -1, 0, 4);
        send(8'h22, 0, -1, -1, 0, 6);
        send(8'h40, 1, -1, 4 * CPB + 8, 0, 8);
        send(8'h55, 1, -1, -1, 0, 4);
        read_exp(8'h55);

        rnd_rd = 1;
        for (int i = 0; i < 30; i++)
            send(8'($urandom_range(0, 255)), $urandom_range(0, 99) < 85,
                 -1, -1, 0, $urandom_range(4, 20));
        rnd_rd = 0;
        @(posedge sourceClk);
        #1;
        rd_en = 1'b1;
        repeat (D + 2) @(posedge sourceClk);
        #1;
        rd_en = 1'b0;
        chk("drain_empty", rx_valid, 0);
        repeat (4) @(posedge sourceClk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
